uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- UART receiver feeding the ASCII-hex instruction loader in the TinyTapeout top; it sits directly upstream of the loader.
- Deserialises 8N1 frames from the `rx` pin using 16x oversampling.
- Presents each byte on `dout` with a sticky `rdy` flag, cleared by the consumer's one-cycle `rdy_clr` pulse.
- Reports framing errors and overruns so the loader can discard corrupted hex digits.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- OVERSAMPLE, 16, ticks per bit; fixed at 16, other values unsupported.
- DIV, CLK_HZ/(BAUD*OVERSAMPLE) (integer division; 27 at defaults), clocks per tick; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-high (block is in reset while rst_n=1).
- rx  in  1  serial input, idle high, asynchronous to clk.
- rdy_clr  in  1  one-cycle pulse from consumer; clears rdy, frame_err, overrun.
- dout  out  8  last correctly framed byte.
- rdy  out  1  new byte available (sticky).
- frame_err  out  1  stop bit sampled low (sticky).
- overrun  out  1  byte completed while rdy still set (sticky).
- busy  out  1  frame reception in progress (state != IDLE).

Behaviour:
- Reset (rst_n=1, async): dout=0, rdy=0, frame_err=0, overrun=0, busy=0, state=IDLE, both sync flops=1, tick and sample counters=0, shift register=0.
- Input sync: rx passes through a 2-flop synchroniser; all logic uses the synced value rs.
- Falling-edge detection: register prev rs.
- Tick generator: counter 0..DIV-1. tick=1 for one clk when counter==DIV-1, then the counter wraps to 0.
  - Counter is forced to 0 on start-edge detection so sampling phase is aligned to the edge.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: on a falling edge of rs (prev=1, rs=0) go to START; sample_cnt=0.
  - START: count ticks. On tick with sample_cnt==7 (mid start bit):
    - rs==0 -> DATA, sample_cnt=0, bit_cnt=0.
    - rs==1 -> IDLE (glitch rejected; no flags change).
  - DATA: on tick with sample_cnt==15, sample rs, shift LSB-first (shreg <= {rs, shreg[7:1]}), bit_cnt++. After the 8th bit go to STOP with sample_cnt=0.
  - STOP: on tick with sample_cnt==15, sample the stop bit.
    - rs==1: dout<=shreg, rdy<=1. If rdy was already 1 and rdy_clr is not asserted this cycle, overrun<=1. dout is overwritten regardless.
    - rs==0: frame_err<=1; dout and rdy unchanged.
    - Either case -> IDLE the same cycle.
- Latency: rdy/dout update 1 clk after the mid-stop-bit tick, i.e. about 9.5 bit periods plus 3 clks after the rx falling edge at the pin.
- rdy_clr: next clk rdy=0, frame_err=0, overrun=0; dout holds.
  - rdy_clr and byte completion in the same cycle: set wins (rdy=1, overrun=0); frame_err set wins likewise.
- A new start edge is accepted only after rs has been seen high (falling-edge detect). A line held low (break) generates one frame_err, then waits in IDLE.
- rx activity never changes rdy/dout except at a valid stop bit.
- Reset mid-frame: immediate return to reset values; the partial byte is discarded.

Test Plan:
- Bench parameters: CLK_HZ=1600000, BAUD=10000 (DIV=10, 160 clk/bit).
- Send 0x41 -> rdy=1 and dout=0x41 within 9.5*160+4 clks of the rx edge; frame_err=0, overrun=0; busy high during the frame, low afterwards.
- After 0x41, pulse rdy_clr for 1 clk -> rdy=0 next clk; dout stays 0x41. Then send 0x30 -> dout=0x30, rdy=1.
- Send 0x31 then 0x32 back-to-back with no rdy_clr -> dout=0x32, rdy=1, overrun=1. Pulse rdy_clr -> rdy=0, overrun=0.
- Send 0x55 with the stop bit driven 0 -> frame_err=1, rdy stays 0, dout unchanged. Then a valid 0x46 -> dout=0x46, rdy=1, frame_err still 1 until rdy_clr.
- Drive rx low for 3 clks, then high -> no rdy and no flags; busy falls within 8 ticks (about 80 clks).
- Assert rst_n=1 mid-way through byte 0x7E -> all outputs 0 immediately. Release and resend 0x7E -> dout=0x7E, rdy=1.

Source files
------------

// File: rtl/uart_rx_core_if.sv
// Consumer-side bundle of the UART receiver: received byte, sticky status
// flags and the one-cycle clear pulse coming back from the hex loader.
interface uart_rx_core_if;
  logic [7:0] dout;
  logic       rdy;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic       rdy_clr;

  // Receiver side: drives data and status, listens to the clear pulse.
  modport master (
    output dout,
    output rdy,
    output frame_err,
    output overrun,
    output busy,
    input  rdy_clr
  );

  // Consumer side: reads data and status, issues the clear pulse.
  modport slave (
    input  dout,
    input  rdy,
    input  frame_err,
    input  overrun,
    input  busy,
    output rdy_clr
  );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling. Start bit is validated at its
// middle, data and stop bits are sampled one bit period apart from there.
// The byte lands in dout with a sticky rdy flag; framing errors and
// overruns are reported as sticky flags cleared by the consumer.
module uart_rx_core #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx_i,
  uart_rx_core_if.master bus
);

  localparam int            DIV       = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int            TW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  logic          sync1_q, sync2_q, prev_q;
  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    sample_cnt_q, sample_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    dout_q, dout_d;
  logic          rdy_q, rdy_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;
  logic          busy_q, busy_d;

  logic          rs_s;
  logic          fall_s;
  logic          tick_s;
  logic          done_ok_s;
  logic          done_bad_s;

  assign rs_s   = sync2_q;
  assign fall_s = prev_q & ~sync2_q;
  assign tick_s = (tick_cnt_q == TICK_LAST);

  // Two-flop synchroniser for the pin plus the previous-value flop used for edge detection.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      sample_cnt_q <= 4'd0;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 8'd0;
      dout_q       <= 8'd0;
      rdy_q        <= 1'b0;
      fe_q         <= 1'b0;
      ov_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      dout_q       <= dout_d;
      rdy_q        <= rdy_d;
      fe_q         <= fe_d;
      ov_q         <= ov_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic: tick generation, frame sequencing and sticky flag updates.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    dout_d       = dout_q;
    rdy_d        = rdy_q;
    fe_d         = fe_q;
    ov_d         = ov_q;
    done_ok_s    = 1'b0;
    done_bad_s   = 1'b0;

    if (tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (fall_s) begin
          // Re-phase the tick counter so sampling is aligned to the start edge.
          state_d      = START;
          sample_cnt_d = 4'd0;
          tick_cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          if (sample_cnt_q == 4'd7) begin
            if (!rs_s) begin
              state_d      = DATA;
              sample_cnt_d = 4'd0;
              bit_cnt_d    = 3'd0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_d = IDLE;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end else begin
          sample_cnt_d = sample_cnt_q;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (sample_cnt_q == 4'd15) begin
            shreg_d      = {rs_s, shreg_q[7:1]};
            sample_cnt_d = 4'd0;
            bit_cnt_d    = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = STOP;
            end else begin
              state_d = DATA;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end else begin
          sample_cnt_d = sample_cnt_q;
        end
      end
      STOP: begin
        if (tick_s) begin
          if (sample_cnt_q == 4'd15) begin
            state_d = IDLE;
            if (rs_s) begin
              done_ok_s = 1'b1;
            end else begin
              done_bad_s = 1'b1;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end else begin
          sample_cnt_d = sample_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Consumer clear first, so a completion in the same cycle wins.
    if (bus.rdy_clr) begin
      rdy_d = 1'b0;
      fe_d  = 1'b0;
      ov_d  = 1'b0;
    end else begin
      rdy_d = rdy_q;
    end

    if (done_ok_s) begin
      dout_d = shreg_q;
      rdy_d  = 1'b1;
      if (rdy_q && !bus.rdy_clr) begin
        ov_d = 1'b1;
      end else begin
        ov_d = ov_d;
      end
    end else begin
      dout_d = dout_q;
    end

    if (done_bad_s) begin
      fe_d = 1'b1;
    end else begin
      fe_d = fe_d;
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.dout      = dout_q;
  assign bus.rdy       = rdy_q;
  assign bus.frame_err = fe_q;
  assign bus.overrun   = ov_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames from the test plan
// followed by random frames, all compared against a frame-level model.
module tb_uart_rx_core;

  localparam int BIT_CLKS = 160;
  localparam int LAT_MAX  = 1524;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic rx    = 1'b1;

  uart_rx_core_if bus_if();

  uart_rx_core #(
    .CLK_HZ    (1600000),
    .BAUD      (10000),
    .OVERSAMPLE(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx_i (rx),
    .bus  (bus_if.master)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Frame-level model of what the consumer should see.
  logic [7:0] m_dout;
  logic       m_rdy, m_fe, m_ov;

  int   lat;
  logic got;
  logic busy_mid;
  logic saw_busy;
  logic fell;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_dout = 8'h00;
    m_rdy  = 1'b0;
    m_fe   = 1'b0;
    m_ov   = 1'b0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input logic stop_b);
    if (stop_b) begin
      if (m_rdy) m_ov = 1'b1;
      m_rdy  = 1'b1;
      m_dout = b;
    end else begin
      m_fe = 1'b1;
    end
  endfunction

  function automatic void model_clr();
    m_rdy = 1'b0;
    m_fe  = 1'b0;
    m_ov  = 1'b0;
  endfunction

  task automatic check_model(input string tag);
    check_val({tag, ".dout"}, {24'd0, bus_if.dout}, {24'd0, m_dout});
    check_val({tag, ".rdy"}, {31'd0, bus_if.rdy}, {31'd0, m_rdy});
    check_val({tag, ".ferr"}, {31'd0, bus_if.frame_err}, {31'd0, m_fe});
    check_val({tag, ".ovr"}, {31'd0, bus_if.overrun}, {31'd0, m_ov});
    check_val({tag, ".busy"}, {31'd0, bus_if.busy}, 32'd0);
  endtask

  // Caller must be sitting on a negedge; the start bit begins immediately.
  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop_b;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic do_frame(input logic [7:0] b, input logic stop_b);
    @(negedge clk);
    send_frame(b, stop_b);
    model_frame(b, stop_b);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus_if.rdy_clr = 1'b1;
    @(negedge clk);
    bus_if.rdy_clr = 1'b0;
    model_clr();
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    int         gap;

    bus_if.rdy_clr = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    check_model("reset");
    rst_n = 1'b0;
    repeat (20) @(negedge clk);

    // First byte with latency and busy observation.
    got = 1'b0; lat = 0; busy_mid = 1'b0;
    @(negedge clk);
    fork
      send_frame(8'h41, 1'b1);
      begin
        for (int c = 1; c <= LAT_MAX; c++) begin
          @(posedge clk);
          #1;
          if (c == 800) busy_mid = bus_if.busy;
          if (bus_if.rdy && !got) begin
            got = 1'b1;
            lat = c;
          end
        end
      end
    join
    model_frame(8'h41, 1'b1);
    check_val("lat_in_budget", {31'd0, got}, 32'd1);
    check_val("lat_after_stop_start", {31'd0, (lat > 1440)}, 32'd1);
    check_val("busy_mid_frame", {31'd0, busy_mid}, 32'd1);
    check_model("b41");

    pulse_clr();
    check_model("clr41");
    do_frame(8'h30, 1'b1);
    check_model("b30");

    // Back-to-back frames without clearing: second one overruns.
    pulse_clr();
    do_frame(8'h31, 1'b1);
    check_model("b31");
    do_frame(8'h32, 1'b1);
    check_model("b32_ovr");
    pulse_clr();
    check_model("clr_ovr");

    // Bad stop bit, then a good byte keeps frame_err until cleared.
    do_frame(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check_model("b55_ferr");
    do_frame(8'h46, 1'b1);
    check_model("b46");
    pulse_clr();
    check_model("clr46");

    // Short low glitch on the line is rejected at mid start bit.
    saw_busy = 1'b0; fell = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    fork
      begin
        repeat (3) @(negedge clk);
        rx = 1'b1;
      end
      begin
        for (int c = 1; c <= 100; c++) begin
          @(posedge clk);
          #1;
          if (bus_if.busy) saw_busy = 1'b1;
          if (saw_busy && !bus_if.busy) fell = 1'b1;
        end
      end
    join
    check_val("glitch_busy_rise", {31'd0, saw_busy}, 32'd1);
    check_val("glitch_busy_fall", {31'd0, fell}, 32'd1);
    check_model("glitch");

    // Break: line held low gives one frame error, then idles while still low.
    @(negedge clk);
    rx = 1'b0;
    repeat (1700) @(negedge clk);
    model_frame(8'h00, 1'b0);
    check_model("break_low");
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check_model("break_rel");
    pulse_clr();

    // Random frames with random clears and gaps.
    for (int k = 0; k < 10; k++) begin
      rb  = 8'($urandom_range(0, 255));
      rs  = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 100);
      if ($urandom_range(0, 1) == 1) pulse_clr();
      repeat (gap) @(negedge clk);
      do_frame(rb, rs);
      if (!rs) repeat (20) @(negedge clk);
      check_model($sformatf("rnd%0d", k));
    end

    // Reset in the middle of 0x7E after making sure flags are set.
    do_frame(8'hA5, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h7E >> i) & 8'h01;
      repeat (BIT_CLKS) @(negedge clk);
    end
    check_val("pre_rst_busy", {31'd0, bus_if.busy}, 32'd1);
    check_val("pre_rst_rdy", {31'd0, bus_if.rdy}, 32'd1);
    rst_n = 1'b1;
    #1;
    model_reset();
    check_model("midrst");
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (20) @(negedge clk);
    do_frame(8'h7E, 1'b1);
    check_model("b7E");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
